// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: operand forwarding, load-use and multi-cycle RAW/structural
// stalls, branch flush priority, and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1D,
  input  logic [AW-1:0] rs2D,
  input  logic          mcD,
  input  logic [AW-1:0] rs1E,
  input  logic [AW-1:0] rs2E,
  input  logic [AW-1:0] rdE,
  input  logic          regwriteE,
  input  logic          loadE,
  input  logic          mc_startE,
  input  logic          pcsrcE,
  input  logic [AW-1:0] rdM,
  input  logic          regwriteM,
  input  logic [AW-1:0] rdW,
  input  logic          regwriteW,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE,
  output logic          mc_busy,
  output logic          mc_done,
  output logic [AW-1:0] mc_rd,
  output logic [CW-1:0] stall_cnt
);

  // state | meaning
  // IDLE  | multi-cycle unit free, waiting for mc_startE
  // BUSY  | op in flight; cnt counts down to the writeback cycle (cnt==0)
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] mc_rd_nxt;
  logic          busy_raw, done_raw;
  logic          lw, ms, stall;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic [AW-1:0] rd_m, input logic we_m,
                                         input logic [AW-1:0] rd_w, input logic we_w);
    if (we_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign forwardAE = fwd_sel(rs1E, rdM, regwriteM, rdW, regwriteW);
  assign forwardBE = fwd_sel(rs2E, rdM, regwriteM, rdW, regwriteW);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_rd_nxt = mc_rd;
    busy_raw  = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (mc_startE) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(MC_LAT - 1);
          mc_rd_nxt = rdE;
        end
      end
      BUSY: begin
        // a second mc_startE here is a protocol violation and is dropped
        busy_raw = 1'b1;
        if (cnt == 4'd0) begin
          done_raw  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mc_busy = busy_raw & ~rst;
  assign mc_done = done_raw & ~rst;

  assign lw    = loadE & regwriteE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));
  assign ms    = mc_busy & (mcD | ((mc_rd != '0) & ((mc_rd == rs1D) | (mc_rd == rs2D))));
  // a taken branch squashes the stalled instructions, so it wins over any stall
  assign stall = (lw | ms) & ~pcsrcE & ~rst;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = (lw | ms | pcsrcE) & ~rst;
  assign flushD = pcsrcE & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mc_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mc_rd <= mc_rd_nxt;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: forwarding table, directed hazard
// sequences, and randomized traffic against a cycle-budget reference model.
module tb_hazard_ctrl_mc;
  localparam int AW = 5, MC_LAT = 4, CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic mcD, regwriteE, loadE, mc_startE, pcsrcE, regwriteM, regwriteW;

  logic [1:0] forwardAE, forwardBE, s_forwardAE, s_forwardBE;
  logic stallF, stallD, flushD, flushE, mc_busy, mc_done;
  logic s_stallF, s_stallD, s_flushD, s_flushE, s_mc_busy, s_mc_done;
  logic [AW-1:0] mc_rd, s_mc_rd;
  logic [CW-1:0] stall_cnt;
  logic [3:0] s_stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.AW(AW), .MC_LAT(MC_LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .mcD(mcD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .loadE(loadE),
    .mc_startE(mc_startE), .pcsrcE(pcsrcE), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd), .stall_cnt(stall_cnt));

  hazard_ctrl_mc #(.AW(AW), .MC_LAT(MC_LAT), .CW(4)) dut_sat (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .mcD(mcD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .loadE(loadE),
    .mc_startE(mc_startE), .pcsrcE(pcsrcE), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
    .stallF(s_stallF), .stallD(s_stallD), .flushD(s_flushD), .flushE(s_flushE),
    .mc_busy(s_mc_busy), .mc_done(s_mc_done), .mc_rd(s_mc_rd), .stall_cnt(s_stall_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the unit is a budget of remaining occupied cycles.
  int            m_left = 0;
  logic [AW-1:0] m_rd = '0;
  int            m_scnt = 0;
  int            m_scnt4 = 0;

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic m_busy();
    return !rst && m_left > 0;
  endfunction
  function automatic logic m_lw();
    return loadE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
  endfunction
  function automatic logic m_ms();
    return m_busy() && (mcD || (m_rd != 0 && (m_rd == rs1D || m_rd == rs2D)));
  endfunction
  function automatic logic m_stall();
    return !rst && (m_lw() || m_ms()) && !pcsrcE;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_rd = '0; m_scnt = 0; m_scnt4 = 0;
    end else begin
      if (m_stall()) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt4 < 15) m_scnt4++;
      end
      if (m_left > 0) m_left--;
      else if (mc_startE) begin m_left = MC_LAT; m_rd = rdE; end
    end
  end

  task automatic check_model();
    logic fe;
    fe = !rst && (m_lw() || m_ms() || pcsrcE);
    chk("rnd_fwdA", forwardAE, m_fwd(rs1E));
    chk("rnd_fwdB", forwardBE, m_fwd(rs2E));
    chk("rnd_stallF", stallF, m_stall());
    chk("rnd_stallD", stallD, m_stall());
    chk("rnd_flushD", flushD, !rst && pcsrcE);
    chk("rnd_flushE", flushE, fe);
    chk("rnd_busy", mc_busy, m_busy());
    chk("rnd_done", mc_done, m_busy() && m_left == 1);
    chk("rnd_mc_rd", mc_rd, m_rd);
    chk("rnd_scnt", stall_cnt, m_scnt);
    chk("rnd_s_fwdA", s_forwardAE, m_fwd(rs1E));
    chk("rnd_s_fwdB", s_forwardBE, m_fwd(rs2E));
    chk("rnd_s_ctl", {s_stallF, s_stallD, s_flushD, s_flushE},
        {m_stall(), m_stall(), !rst && pcsrcE, fe});
    chk("rnd_s_mc", {s_mc_busy, s_mc_done, s_mc_rd},
        {m_busy(), m_busy() && m_left == 1, m_rd});
    chk("rnd_s_scnt", s_stall_cnt, m_scnt4);
  endtask

  task automatic clr_in();
    rs1D = '0; rs2D = '0; mcD = 0; rs1E = '0; rs2E = '0; rdE = '0;
    regwriteE = 0; loadE = 0; mc_startE = 0; pcsrcE = 0;
    rdM = '0; regwriteM = 0; rdW = '0; regwriteW = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [AW-1:0] rs1E, rs2E, rdM, rdW;
    logic          rwM, rwW;
    logic [1:0]    expA, expB;
  } fvec_t;
  fvec_t fv[7];

  initial begin
    fv[0] = '{5'd3,  5'd0,  5'd3,  5'd3,  1'b1, 1'b1, 2'b10, 2'b00};
    fv[1] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
    fv[2] = '{5'd4,  5'd6,  5'd6,  5'd4,  1'b1, 1'b1, 2'b01, 2'b10};
    fv[3] = '{5'd4,  5'd4,  5'd4,  5'd4,  1'b0, 1'b1, 2'b01, 2'b01};
    fv[4] = '{5'd8,  5'd9,  5'd8,  5'd9,  1'b1, 1'b0, 2'b10, 2'b00};
    fv[5] = '{5'd31, 5'd31, 5'd30, 5'd31, 1'b1, 1'b1, 2'b01, 2'b01};
    fv[6] = '{5'd0,  5'd2,  5'd0,  5'd2,  1'b1, 1'b1, 2'b00, 2'b01};

    clr_in();
    rst = 1;
    next_cycle();
    // reset: forwarding stays live, control outputs are quiet
    rs1E = 5'd3; rdM = 5'd3; regwriteM = 1; mcD = 1; pcsrcE = 1;
    loadE = 1; regwriteE = 1; rdE = 5'd5; rs2D = 5'd5;
    @(negedge clk);
    chk("rst_fwdA", forwardAE, 2'b10);
    chk("rst_ctl", {stallF, stallD, flushD, flushE, mc_busy, mc_done}, 6'b0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_mc_rd", mc_rd, 0);
    next_cycle();

    // load-use: one stall cycle
    clr_in(); rst = 0;
    loadE = 1; regwriteE = 1; rdE = 5'd5; rs2D = 5'd5;
    @(negedge clk);
    chk("lu_stall", {stallF, stallD, flushE, flushD}, 4'b1110);
    next_cycle();
    clr_in();
    @(negedge clk);
    chk("lu_release", {stallF, stallD, flushE}, 3'b000);
    chk("lu_scnt", stall_cnt, 1);
    next_cycle();

    // multi-cycle RAW on rd=7
    mc_startE = 1; rdE = 5'd7;
    @(negedge clk);
    chk("mc_issue_busy", mc_busy, 0);
    next_cycle();
    clr_in(); rs1D = 5'd7;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("mc_raw_busy", mc_busy, i <= 4);
      chk("mc_raw_done", mc_done, i == 4);
      chk("mc_raw_stall", stallD, i <= 4);
      if (i == 1) chk("mc_raw_rd", mc_rd, 7);
      next_cycle();
    end
    chk("mc_raw_scnt", stall_cnt, 5);

    // structural hazard with an independent instruction slipped in
    clr_in(); mc_startE = 1; rdE = 5'd9;
    next_cycle();
    clr_in();
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin mcD = 0; rs1D = 5'd1; rs2D = 5'd2; end
      else begin mcD = 1; rs1D = '0; rs2D = '0; end
      @(negedge clk);
      chk("struct_stall", stallD, i != 2 && i <= 4);
      if (i == 5) chk("struct_scnt", stall_cnt, 8);
      next_cycle();
    end

    // branch wins over load-use; in-flight op still completes
    clr_in(); mc_startE = 1; rdE = 5'd4;
    next_cycle();
    clr_in(); pcsrcE = 1; loadE = 1; regwriteE = 1; rdE = 5'd6; rs1D = 5'd6;
    @(negedge clk);
    chk("br_ctl", {stallF, stallD, flushD, flushE, mc_busy}, 5'b00111);
    next_cycle();
    clr_in();
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("br_done", {mc_busy, mc_done}, {1'b1, i == 4});
      next_cycle();
    end
    chk("br_scnt", stall_cnt, 8);

    // reset in 2nd BUSY cycle aborts the op
    clr_in(); mc_startE = 1; rdE = 5'd3;
    next_cycle();
    clr_in();
    @(negedge clk);
    chk("ra_busy1", mc_busy, 1);
    next_cycle();
    rst = 1; mcD = 1; pcsrcE = 1; loadE = 1; regwriteE = 1; rdE = 5'd5; rs1D = 5'd5;
    @(negedge clk);
    chk("ra_in_rst", {stallF, stallD, flushD, flushE, mc_busy, mc_done}, 6'b0);
    next_cycle();
    clr_in(); rst = 0; mcD = 1;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      chk("ra_after", {mc_busy, mc_done, stallD}, 3'b000);
      chk("ra_scnt", stall_cnt, 0);
      next_cycle();
    end

    // 20 forced stall cycles: CW=4 instance saturates at 15
    clr_in(); loadE = 1; regwriteE = 1; rdE = 5'd5; rs1D = 5'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) chk("sat_mid", s_stall_cnt, 10);
      next_cycle();
    end
    clr_in();
    @(negedge clk);
    chk("sat_cw4", s_stall_cnt, 15);
    chk("sat_cw16", stall_cnt, 20);

    // forwarding table
    for (int i = 0; i < 7; i++) begin
      clr_in();
      rs1E = fv[i].rs1E; rs2E = fv[i].rs2E; rdM = fv[i].rdM; rdW = fv[i].rdW;
      regwriteM = fv[i].rwM; regwriteW = fv[i].rwW;
      #1;
      chk($sformatf("fwd_tbl%0d_A", i), forwardAE, fv[i].expA);
      chk($sformatf("fwd_tbl%0d_B", i), forwardBE, fv[i].expB);
    end
    next_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      rs1D      = AW'($urandom_range(0, 3));
      rs2D      = AW'($urandom_range(0, 3));
      mcD       = ($urandom_range(0, 5) == 0);
      rs1E      = AW'($urandom_range(0, 3));
      rs2E      = AW'($urandom_range(0, 3));
      rdE       = AW'($urandom_range(0, 3));
      regwriteE = $urandom_range(0, 1);
      loadE     = ($urandom_range(0, 3) == 0);
      mc_startE = ($urandom_range(0, 4) == 0);
      pcsrcE    = ($urandom_range(0, 7) == 0);
      rdM       = AW'($urandom_range(0, 3));
      regwriteM = $urandom_range(0, 1);
      rdW       = AW'($urandom_range(0, 3));
      regwriteW = $urandom_range(0, 1);
      @(negedge clk);
      check_model();
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Parameters
REQ-001 The block SHALL have parameter AW, default 5, meaning the register-index width.
REQ-002 The block SHALL have parameter MC_LAT, default 4 (legal 2..15), meaning the multi-cycle unit latency in cycles from issue to writeback.
REQ-003 The block SHALL have parameter CW, default 16, meaning the stall-cycle counter width.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports rs1D and rs2D, input, AW bits each: decode-stage source registers.
REQ-007 The block SHALL have port mcD, input, 1 bit: the decode instruction is a multi-cycle (MUL/DIV) op.
REQ-008 The block SHALL have ports rs1E, rs2E and rdE, input, AW bits each: execute-stage source and destination registers.
REQ-009 The block SHALL have ports regwriteE and loadE, input, 1 bit each: the execute-stage instruction writes a register / is a load.
REQ-010 The block SHALL have port mc_startE, input, 1 bit: the execute-stage instruction issues to the multi-cycle unit.
REQ-011 The block SHALL have port pcsrcE, input, 1 bit: a taken branch or jump resolved in E.
REQ-012 The block SHALL have ports rdM and regwriteM, input, AW and 1 bit: memory-stage destination and its write enable.
REQ-013 The block SHALL have ports rdW and regwriteW, input, AW and 1 bit: writeback-stage destination and its write enable.
REQ-014 The block SHALL have ports forwardAE and forwardBE, output, 2 bits each: operand select, 00 = register file, 10 = M result, 01 = W result.
REQ-015 The block SHALL have ports stallF, stallD, flushD and flushE, output, 1 bit each: pipeline control.
REQ-016 The block SHALL have port mc_busy, output, 1 bit: the multi-cycle unit is occupied.
REQ-017 The block SHALL have port mc_done, output, 1 bit: one-cycle pulse; the multi-cycle result writes the register file this cycle.
REQ-018 The block SHALL have port mc_rd, output, AW bits: the destination of the pending multi-cycle op.
REQ-019 The block SHALL have port stall_cnt, output, CW bits: saturating count of cycles with stallD=1.

Function
REQ-020 Forwarding SHALL be combinational, with forwardAE = 10 when regwriteM & rdM!=0 & rdM==rs1E, else 01 when regwriteW & rdW!=0 & rdW==rs1E, else 00; forwardBE is identical using rs2E.
REQ-021 A destination of register 0 SHALL never produce forwarding, and M SHALL take priority over W.
REQ-022 Load-use stall (lw) SHALL be asserted when loadE & regwriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
REQ-023 The FSM SHALL have states IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-024 In IDLE with mc_startE=1, the FSM SHALL go to BUSY, set cnt=MC_LAT-1 and capture mc_rd=rdE.
REQ-025 In BUSY the FSM SHALL decrement cnt each cycle; the cycle with cnt==0 SHALL assert mc_done=1, and the next state SHALL be IDLE.
REQ-026 mc_startE asserted while BUSY SHALL be ignored (protocol violation; decode stalls prevent it).
REQ-027 mc_busy SHALL be 1 in BUSY, including the mc_done cycle.
REQ-028 Multi-cycle stall (ms) SHALL be asserted when mc_busy & (mcD | (mc_rd!=0 & (mc_rd==rs1D | mc_rd==rs2D))), including the mc_done cycle, and released the cycle after.
REQ-029 mc_startE with rdE=0 SHALL still occupy the unit for MC_LAT cycles, with no RAW stall on register 0.
REQ-030 Outputs SHALL be stallF = stallD = (lw|ms) & ~pcsrcE, flushE = lw | ms | pcsrcE, and flushD = pcsrcE.
REQ-031 pcsrcE SHALL override stalls and SHALL NOT cancel a BUSY multi-cycle op, since the issuing instruction is older than the branch.
REQ-032 lw and ms asserted together SHALL produce a single stall per cycle; stalls persist until both clear.
REQ-033 stall_cnt SHALL increment by 1 on each cycle with stallD=1 and hold at 2^CW-1 with no wrap.

Reset
REQ-034 While rst=1 at a rising edge, the block SHALL set state to IDLE and cnt, mc_rd and stall_cnt to 0.
REQ-035 While rst=1, mc_busy, mc_done, stallF, stallD, flushD and flushE SHALL be 0.
REQ-036 While rst=1, forwardAE and forwardBE SHALL remain combinational functions of their inputs.
REQ-037 Reset asserted mid-BUSY SHALL abort the op with no mc_done pulse, and the block SHALL be IDLE the first cycle after rst falls.

Verification
REQ-038 The bench SHALL cover forwarding: rs1E=3, rdM=3, regwriteM=1, rdW=3, regwriteW=1 -> forwardAE=10; rdM=0, rdW=0, regwriteM=1, regwriteW=1, rs1E=0 -> forwardAE=00.
REQ-039 The bench SHALL cover load-use: loadE=1, regwriteE=1, rdE=5, rs2D=5 -> stallF=stallD=flushE=1 for exactly one cycle, and stall_cnt increments by 1.
REQ-040 The bench SHALL cover multi-cycle RAW: mc_startE=1, rdE=7, MC_LAT=4, then rs1D=7 -> mc_busy for 4 cycles, mc_done on the 4th, stallD=1 for 4 cycles, and 0 on the 5th.
REQ-041 The bench SHALL cover the structural hazard: mcD=1 while BUSY -> stallD=1 until the cycle after mc_done; an independent decode instruction (rs1D=1, rs2D=2, mcD=0) sees no stall.
REQ-042 The bench SHALL cover branch priority: pcsrcE=1 together with lw conditions -> stallF=stallD=0, flushD=flushE=1, and an in-flight BUSY op still pulses mc_done on schedule.
REQ-043 The bench SHALL cover reset and saturation: rst=1 in the 2nd BUSY cycle -> no mc_done and all outputs 0; with CW=4 and 20 forced stall cycles -> stall_cnt=15.
